// File: rtl/ram_arbiter.sv
// ram_arbiter
// -----------------------------------------------------------------------------
// Shares the single-port stack/data RAM between the core stack sequencer and
// the debugger host port. One transaction is in flight at a time and each one
// walks IDLE -> ISSUE -> CAPTURE -> IDLE.
//
// Build option:
//   RAM_ARB_DEBUG_PRIORITY_EN  defined   : fixed priority, debug wins over core
//                              undefined : round-robin between the two ports
//
// Ports:
//   clk, rst                       system clock, synchronous active-high reset
//   core_req/we/addr/wdata         core access request (held until core_ack)
//   core_ack, core_rdata           one-cycle completion pulse, read data
//   dbg_req/we/addr/wdata          debug access request (held until dbg_ack)
//   dbg_ack, dbg_rdata             one-cycle completion pulse, read data
//   ram_address, ram_inputData     RAM address / write data (held between txns)
//   ram_WRen                       RAM write enable, one cycle per write
//   ram_outputData                 RAM q, valid the cycle after address sample
//   busy                           high whenever the FSM is not IDLE
//   owner                          0 = core, 1 = debug; last/current grant
//   fsm_state                      current FSM state, for observation
//
// Handshake (both ports): the requester raises req with we/addr/wdata stable
// and holds it until ack. Inputs are sampled only on the grant edge; ack is a
// one-cycle pulse and rdata is valid while ack is high. A port whose ack is
// high in the current cycle is not eligible for a grant in that cycle, so a
// req left high through the ack cycle is treated as a new request afterwards.
// -----------------------------------------------------------------------------
module ram_arbiter #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_ack,
  output logic [DATA_W-1:0] core_rdata,

  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,

  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_inputData,
  output logic              ram_WRen,
  input  logic [DATA_W-1:0] ram_outputData,

  output logic              busy,
  output logic              owner,
  output logic [1:0]        fsm_state
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_DBG  = 1'b1;

  logic [1:0] state;
  // Port that wins the next tie. Kept separate from owner so that the first
  // tie after reset goes to the core even though owner also resets to core.
  logic       rr_ptr;
  // we of the granted transaction, needed in CAPTURE after ram_WRen drops.
  logic       txn_we;

  logic       core_elig;
  logic       dbg_elig;
  logic       grant_valid;
  logic       grant_dbg;

  assign fsm_state = state;

  // ---------------------------------------------------------------------------
  // Eligibility and arbitration (only acted upon in IDLE)
  // ---------------------------------------------------------------------------
  always_comb begin
    core_elig   = 1'b0;
    dbg_elig    = 1'b0;
    grant_valid = 1'b0;
    grant_dbg   = PORT_CORE;

    dbg_elig  = dbg_req & ~dbg_ack;
`ifdef RAM_ARB_DEBUG_PRIORITY_EN
    // A held debug req also blocks the core during the debug ack cycle, so a
    // continuously requesting debugger keeps the core off the RAM entirely.
    core_elig = core_req & ~core_ack & ~dbg_req;
`else
    core_elig = core_req & ~core_ack;
`endif

    grant_valid = core_elig | dbg_elig;
    if (core_elig && dbg_elig) begin
      grant_dbg = rr_ptr;
    end else begin
      grant_dbg = dbg_elig;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      rr_ptr        <= PORT_CORE;
      txn_we        <= 1'b0;
      ram_address   <= '0;
      ram_inputData <= '0;
      ram_WRen      <= 1'b0;
      core_ack      <= 1'b0;
      core_rdata    <= '0;
      dbg_ack       <= 1'b0;
      dbg_rdata     <= '0;
      busy          <= 1'b0;
      owner         <= PORT_CORE;
    end else begin
      // Acks are single-cycle pulses; only CAPTURE raises one.
      core_ack <= 1'b0;
      dbg_ack  <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            state  <= ST_ISSUE;
            busy   <= 1'b1;
            owner  <= grant_dbg;
            rr_ptr <= ~grant_dbg;
            if (grant_dbg) begin
              ram_address   <= dbg_addr;
              ram_inputData <= dbg_wdata;
              ram_WRen      <= dbg_we;
              txn_we        <= dbg_we;
            end else begin
              ram_address   <= core_addr;
              ram_inputData <= core_wdata;
              ram_WRen      <= core_we;
              txn_we        <= core_we;
            end
          end
        end

        ST_ISSUE: begin
          // RAM samples address/write on this edge; the write lasts one cycle.
          state    <= ST_CAPTURE;
          ram_WRen <= 1'b0;
        end

        ST_CAPTURE: begin
          // ram_outputData now holds the word addressed during ISSUE.
          state <= ST_IDLE;
          busy  <= 1'b0;
          if (owner == PORT_DBG) begin
            dbg_ack <= 1'b1;
            if (!txn_we) begin
              dbg_rdata <= ram_outputData;
            end
          end else begin
            core_ack <= 1'b1;
            if (!txn_we) begin
              core_rdata <= ram_outputData;
            end
          end
        end

        default: begin
          state    <= ST_IDLE;
          busy     <= 1'b0;
          ram_WRen <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
// -----------------------------------------------------------------------------
// Directed bench for ram_arbiter (default round-robin build). A behavioural
// single-port RAM with a one-cycle registered read sits on the RAM side.
// Inputs are driven 1 ns after the rising edge and outputs sampled there too.
// -----------------------------------------------------------------------------
module tb_ram_arbiter;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 8;

  logic              clk;
  logic              rst;
  logic              core_req;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic              core_ack;
  logic [DATA_W-1:0] core_rdata;
  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_ack;
  logic [DATA_W-1:0] dbg_rdata;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_inputData;
  logic              ram_WRen;
  logic [DATA_W-1:0] ram_outputData;
  logic              busy;
  logic              owner;
  logic [1:0]        fsm_state;

  int vectors;
  int miscompares;

  logic [DATA_W-1:0] exp_core_rdata;
  logic [DATA_W-1:0] exp_dbg_rdata;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // DUT
  // ---------------------------------------------------------------------------
  ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .core_req       (core_req),
    .core_we        (core_we),
    .core_addr      (core_addr),
    .core_wdata     (core_wdata),
    .core_ack       (core_ack),
    .core_rdata     (core_rdata),
    .dbg_req        (dbg_req),
    .dbg_we         (dbg_we),
    .dbg_addr       (dbg_addr),
    .dbg_wdata      (dbg_wdata),
    .dbg_ack        (dbg_ack),
    .dbg_rdata      (dbg_rdata),
    .ram_address    (ram_address),
    .ram_inputData  (ram_inputData),
    .ram_WRen       (ram_WRen),
    .ram_outputData (ram_outputData),
    .busy           (busy),
    .owner          (owner),
    .fsm_state      (fsm_state)
  );

  // Single-port RAM, registered read (old data on read-during-write).
  always @(posedge clk) begin
    if (ram_WRen) mem[ram_address] <= ram_inputData;
    ram_outputData <= mem[ram_address];
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"},   32'(fsm_state),     32'd0);
    check({tag, "_addr"},    32'(ram_address),   32'd0);
    check({tag, "_wdata"},   32'(ram_inputData), 32'd0);
    check({tag, "_wren"},    32'(ram_WRen),      32'd0);
    check({tag, "_cack"},    32'(core_ack),      32'd0);
    check({tag, "_dack"},    32'(dbg_ack),       32'd0);
    check({tag, "_crdata"},  32'(core_rdata),    32'd0);
    check({tag, "_drdata"},  32'(dbg_rdata),     32'd0);
    check({tag, "_busy"},    32'(busy),          32'd0);
    check({tag, "_owner"},   32'(owner),         32'd0);
  endtask

  // One uncontended transaction on one port, starting from IDLE with no ack
  // pending. Checks grant, the single write cycle, ack latency and rdata.
  task automatic xact(input string tag, input logic port, input logic we,
                      input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                      input logic [DATA_W-1:0] rd_exp);
    if (port) begin
      dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
    end else begin
      core_req = 1'b1; core_we = we; core_addr = addr; core_wdata = wdata;
    end
    step();  // grant edge
    check({tag, "_e0_busy"},  32'(busy),        32'd1);
    check({tag, "_e0_owner"}, 32'(owner),       32'(port));
    check({tag, "_e0_addr"},  32'(ram_address), 32'(addr));
    check({tag, "_e0_wren"},  32'(ram_WRen),    32'(we));
    if (we) check({tag, "_e0_wdata"}, 32'(ram_inputData), 32'(wdata));
    step();  // RAM access edge
    check({tag, "_e1_wren"},  32'(ram_WRen), 32'd0);
    check({tag, "_e1_cack"},  32'(core_ack), 32'd0);
    check({tag, "_e1_dack"},  32'(dbg_ack),  32'd0);
    step();  // capture edge: ack cycle
    if (!we) begin
      if (port) exp_dbg_rdata = rd_exp;
      else      exp_core_rdata = rd_exp;
    end
    check({tag, "_e2_cack"},   32'(core_ack),   32'(!port));
    check({tag, "_e2_dack"},   32'(dbg_ack),    32'(port));
    check({tag, "_e2_crdata"}, 32'(core_rdata), 32'(exp_core_rdata));
    check({tag, "_e2_drdata"}, 32'(dbg_rdata),  32'(exp_dbg_rdata));
    if (port) dbg_req = 1'b0;
    else      core_req = 1'b0;
    step();
    check({tag, "_e3_cack"}, 32'(core_ack), 32'd0);
    check({tag, "_e3_dack"}, 32'(dbg_ack),  32'd0);
    check({tag, "_e3_busy"}, 32'(busy),     32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    vectors        = 0;
    miscompares    = 0;
    exp_core_rdata = '0;
    exp_dbg_rdata  = '0;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;

    rst = 1'b1;
    core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
    dbg_req  = 1'b0; dbg_we  = 1'b0; dbg_addr  = '0; dbg_wdata  = '0;

    // Reset values
    step(); step(); step();
    check_reset_values("rst0");
    rst = 1'b0;

    // Core write 0x7FF <- 0xA5, ack three cycles after the grant sample
    xact("t1_core_wr", 1'b0, 1'b1, 11'h7FF, 8'hA5, 8'h00);

    // Core write, core read, debug read of the core's data
    xact("t2_core_wr", 1'b0, 1'b1, 11'h010, 8'h3C, 8'h00);
    xact("t2_core_rd", 1'b0, 1'b0, 11'h7FF, 8'h00, 8'hA5);
    xact("t2_dbg_rd",  1'b1, 1'b0, 11'h010, 8'h00, 8'h3C);

    // Contention right after reset: core, dbg, core, acks 3 cycles apart
    rst = 1'b1;
    step();
    check_reset_values("t3_rst");
    exp_core_rdata = '0;
    exp_dbg_rdata  = '0;
    rst = 1'b0;
    core_req = 1'b1; core_we = 1'b0; core_addr = 11'h7FF;
    dbg_req  = 1'b1; dbg_we  = 1'b0; dbg_addr  = 11'h010;
    for (int i = 1; i <= 9; i++) begin
      step();
      check($sformatf("t3_c%0d_cack", i), 32'(core_ack), 32'(i == 3 || i == 9));
      check($sformatf("t3_c%0d_dack", i), 32'(dbg_ack),  32'(i == 6));
      if (i == 1 || i == 7) check($sformatf("t3_c%0d_owner", i), 32'(owner), 32'd0);
      if (i == 4)           check($sformatf("t3_c%0d_owner", i), 32'(owner), 32'd1);
      if (i == 3 || i == 9) check($sformatf("t3_c%0d_crdata", i), 32'(core_rdata), 32'hA5);
      if (i == 6)           check($sformatf("t3_c%0d_drdata", i), 32'(dbg_rdata),  32'h3C);
    end
    core_req = 1'b0;
    dbg_req  = 1'b0;
    step();
    check("t3_end_busy", 32'(busy),    32'd0);
    check("t3_end_cack", 32'(core_ack), 32'd0);
    check("t3_end_dack", 32'(dbg_ack),  32'd0);
    step();
    check("t3_end2_busy", 32'(busy), 32'd0);
    exp_core_rdata = 8'hA5;
    exp_dbg_rdata  = 8'h3C;

    // Core holds a read of 0x005 through its ack: acks 4 cycles apart
    xact("t4_core_wr", 1'b0, 1'b1, 11'h005, 8'h5A, 8'h00);
    core_req = 1'b1; core_we = 1'b0; core_addr = 11'h005;
    for (int i = 1; i <= 7; i++) begin
      step();
      check($sformatf("t4_c%0d_busy", i), 32'(busy),     32'(i == 1 || i == 2 || i == 5 || i == 6));
      check($sformatf("t4_c%0d_cack", i), 32'(core_ack), 32'(i == 3 || i == 7));
      if (i == 3 || i == 7) check($sformatf("t4_c%0d_crdata", i), 32'(core_rdata), 32'h5A);
      if (i == 7) core_req = 1'b0;
    end
    step();
    check("t4_end_busy", 32'(busy),     32'd0);
    check("t4_end_cack", 32'(core_ack), 32'd0);
    exp_core_rdata = 8'h5A;

    // Reset during the ISSUE cycle of a debug write
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 11'h123; dbg_wdata = 8'h77;
    step();
    check("t5_issue_state", 32'(fsm_state), 32'd1);
    check("t5_issue_wren",  32'(ram_WRen),  32'd1);
    check("t5_issue_owner", 32'(owner),     32'd1);
    rst = 1'b1;
    step();
    check_reset_values("t5_abort");
    exp_core_rdata = '0;
    exp_dbg_rdata  = '0;
    rst = 1'b0;
    dbg_req = 1'b0;
    step();
    check("t5_post1_dack", 32'(dbg_ack), 32'd0);
    step();
    check("t5_post2_dack", 32'(dbg_ack), 32'd0);
    check("t5_post2_busy", 32'(busy),    32'd0);

    // Inputs change after the grant edge: access still targets 0x100
    xact("t6_dbg_wr1", 1'b1, 1'b1, 11'h100, 8'h11, 8'h00);
    xact("t6_dbg_wr2", 1'b1, 1'b1, 11'h200, 8'h22, 8'h00);
    core_req = 1'b1; core_we = 1'b0; core_addr = 11'h100;
    step();
    check("t6_e0_addr", 32'(ram_address), 32'h100);
    core_addr = 11'h200;
    core_req  = 1'b0;
    step();
    check("t6_e1_addr", 32'(ram_address), 32'h100);
    check("t6_e1_busy", 32'(busy),        32'd1);
    step();
    check("t6_e2_cack",   32'(core_ack),   32'd1);
    check("t6_e2_crdata", 32'(core_rdata), 32'h11);
    step();
    check("t6_e3_cack", 32'(core_ack), 32'd0);
    check("t6_e3_busy", 32'(busy),     32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Shares the single-port stack/data RAM (11-bit address, 8-bit data, one-cycle registered read) between two requesters: the CPU core's stack sequencer (call/ret push and pop) and the debugger host port, which inspects and patches RAM. It owns the RAM's address, write-data and write-enable inputs. Each access runs through a req/ack handshake, and the block grants at most one transaction at a time. It sits between the core FSM, the debug interface and the RAM instance.

## Interface
- ADDR_W, 11, RAM address width
- DATA_W, 8, RAM data width
- clk  in  1  system clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- core_req  in  1  core requests an access; held until core_ack
- core_we  in  1  1 = write, 0 = read
- core_addr  in  ADDR_W  access address
- core_wdata  in  DATA_W  write data
- core_ack  out  1  one-cycle completion pulse
- core_rdata  out  DATA_W  read data, valid while core_ack = 1
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_ack, dbg_rdata: same as the core_* ports, for the debug port
- ram_address  out  ADDR_W  to RAM address
- ram_inputData  out  DATA_W  to RAM data in
- ram_WRen  out  1  to RAM write enable
- ram_outputData  in  DATA_W  from RAM q; valid the cycle after RAM samples the address
- busy  out  1  high whenever state is not IDLE
- owner  out  1  0 = core, 1 = debug; last/current granted port

## Operation
- FSM states and transitions:
  - IDLE: go to ISSUE when an eligible req is present.
  - ISSUE: always go to CAPTURE.
  - CAPTURE: always go to IDLE.
- All outputs are registered. Reset values:
  - State IDLE.
  - ram_address = 0, ram_inputData = 0, ram_WRen = 0.
  - Both acks = 0, both rdata = 0.
  - busy = 0, owner = 0.
  - Round-robin pointer = core.
- Eligibility: a port is eligible in IDLE if its req = 1 and its ack is not asserted in that same cycle. This stops a just-acked port's stale req from being regranted.
- Arbitration in IDLE:
  - If exactly one port is eligible, it wins.
  - If both are eligible, the port that is not owner wins (round-robin). After reset, core wins the first tie.
- Grant (IDLE→ISSUE edge):
  - Latch the winner's addr into ram_address and its wdata into ram_inputData.
  - Set ram_WRen = winner's we.
  - Set owner = winner.
- ISSUE→CAPTURE edge: the RAM samples the address and write. Clear ram_WRen, so a write is exactly one RAM cycle.
- CAPTURE→IDLE edge:
  - Set the owner's ack = 1 for one cycle.
  - For a read, load the owner's rdata from ram_outputData. For a write, rdata keeps its previous value.
  - The other port's ack and rdata are unchanged.
- ram_address and ram_inputData hold their last values when no transaction is active.
- Requester inputs are sampled only on the grant edge. A requester that changes them or drops req after grant does not affect the transaction, and ack is still issued.
- Reset mid-transaction: abort, return to IDLE, ram_WRen = 0, no ack is issued. The aborted transaction is lost.

## Timing
- The grant edge is E0, with req sampled there.
  - RAM access at E1.
  - ack is high in the cycle after E2, with rdata valid in that same cycle.
- Latency from req (sampled at E0) to ack high is 3 cycles. Max throughput is one transaction per 3 cycles.
- The same port back-to-back is one transaction per 4 cycles, because of the ack-cycle ineligibility.
- Alternating ports achieve one per 3 cycles: the other port is granted on the edge ending the ack cycle.
- Worst-case wait for a held req under contention is 6 cycles in round-robin mode.
- ram_WRen is high for exactly one cycle per write and never during reads.

## Configuration
- RAM_ARB_DEBUG_PRIORITY_EN defined: fixed priority. If both ports are eligible, debug always wins and the round-robin pointer is ignored. A continuously requesting debugger can therefore starve the core, which is intentional so a halted core can be inspected.
- Not defined: round-robin as described in Operation.

## Test plan
- Reset, then core write addr 0x7FF, data 0xA5 → ram_WRen high for exactly 1 cycle with ram_address = 0x7FF and ram_inputData = 0xA5; core_ack pulses 3 cycles after req; dbg_ack stays 0.
- Core write 0x3C at 0x010, then dbg read 0x010 → dbg_ack pulses with dbg_rdata = 0x3C; core_rdata unchanged.
- Both req asserted on the same cycle immediately after reset, both held → grants alternate: core first, then dbg, then core. Acks are spaced 3 cycles apart with no lost or duplicated ack. With RAM_ARB_DEBUG_PRIORITY_EN, only dbg is acked while its req is held.
- Core holds req through its ack with an unchanged read addr 0x005 → second grant occurs only after the ack cycle, giving exactly 2 acks 4 cycles apart; the ack-cycle req is never regranted.
- rst asserted in the ISSUE cycle of a write → next cycle state is IDLE, ram_WRen = 0, no ack, all outputs at reset values.
- Requester changes addr from 0x100 to 0x200 and drops req after the grant edge → access still targets 0x100 and ack is still issued.
